// File: rtl/inst_loop_sequencer.sv
// Instruction loop sequencer: queues loop descriptors and expands each into paced
// SYSTOLIC_ARRAY instructions plus an IDLE trailer. SEQ_IDLE_SYNC_EN adds the idle_flag stall.
//
// state      | meaning
// S_IDLE     | no loop running; pops the descriptor FIFO when non-empty
// S_WAIT_HI  | loop instruction presented, waiting for flag high
// S_WAIT_LO  | array stepping, waiting for flag low
// S_SYNC     | iteration-1 instruction held until idle_flag low (SEQ_IDLE_SYNC_EN only)
// S_TRAIL_HI | IDLE trailer presented, waiting for flag high
// S_TRAIL_LO | trailer stepping, waiting for flag low
module inst_loop_sequencer #(
  parameter int OPCODE_BITS = 4,
  parameter int ADDR_BITS   = 16,
  parameter int CNT_BITS    = 16,
  parameter int DESC_DEPTH  = 4,
  parameter logic [OPCODE_BITS-1:0] IDLE_OPCODE = '0
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               desc_valid,
  output logic                               desc_ready,
  input  logic [OPCODE_BITS-1:0]             desc_opcode,
  input  logic [ADDR_BITS-1:0]               desc_addra_base,
  input  logic [ADDR_BITS-1:0]               desc_addra_stride,
  input  logic [ADDR_BITS-1:0]               desc_addrb_base,
  input  logic [ADDR_BITS-1:0]               desc_addrb_stride,
  input  logic [CNT_BITS-1:0]                desc_count,
  output logic [OPCODE_BITS+2*ADDR_BITS-1:0] instruction,
  input  logic                               flag,
  input  logic                               idle_flag,
  output logic                               busy,
  output logic                               done,
  output logic [$clog2(DESC_DEPTH):0]        fifo_level
);

  localparam int PTR_BITS = $clog2(DESC_DEPTH);
  localparam int LVL_BITS = PTR_BITS + 1;
  localparam int DESC_W   = OPCODE_BITS + 4*ADDR_BITS + CNT_BITS;
  localparam logic [LVL_BITS-1:0] FULL_LVL = LVL_BITS'(DESC_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_HI,
    S_WAIT_LO,
    S_TRAIL_HI,
    S_TRAIL_LO
`ifdef SEQ_IDLE_SYNC_EN
    , S_SYNC
`endif
  } state_t;

  logic [DESC_W-1:0]      fifo_mem_q [DESC_DEPTH];
  logic [PTR_BITS-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_BITS-1:0]    level_q, level_d;
  logic                   push, pop;
  logic [DESC_W-1:0]      head;
  logic [OPCODE_BITS-1:0] head_op;
  logic [ADDR_BITS-1:0]   head_abase, head_astr, head_bbase, head_bstr;
  logic [CNT_BITS-1:0]    head_cnt;

  state_t                 state_q, state_d;
  logic [OPCODE_BITS-1:0] opcode_q, opcode_d, loop_op_q, loop_op_d;
  logic [ADDR_BITS-1:0]   addra_q, addra_d, addrb_q, addrb_d;
  logic [ADDR_BITS-1:0]   stra_q, stra_d, strb_q, strb_d;
  logic [CNT_BITS-1:0]    idx_q, idx_d, cnt_q, cnt_d;
  logic                   busy_q, busy_d, done_q, done_d;
  logic [CNT_BITS:0]      idx_inc;
  logic                   more_iter;

  assign desc_ready  = (level_q != FULL_LVL);
  assign push        = desc_valid && desc_ready;
  assign head        = fifo_mem_q[rd_ptr_q];
  assign {head_op, head_abase, head_astr, head_bbase, head_bstr, head_cnt} = head;

  assign instruction = {opcode_q, addra_q, addrb_q};
  assign busy        = busy_q;
  assign done        = done_q;
  assign fifo_level  = level_q;

  // Extra bit keeps index+1 < count exact when count is at its maximum.
  assign idx_inc   = {1'b0, idx_q} + (CNT_BITS+1)'(1);
  assign more_iter = idx_inc < {1'b0, cnt_q};

`ifndef SEQ_IDLE_SYNC_EN
  logic unused_idle_flag;
  assign unused_idle_flag = idle_flag;
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= {desc_opcode, desc_addra_base, desc_addra_stride,
                               desc_addrb_base, desc_addrb_stride, desc_count};
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_BITS'(1);
      2'b01:   level_d = level_q - LVL_BITS'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    loop_op_d = loop_op_q;
    addra_d   = addra_q;
    addrb_d   = addrb_q;
    stra_d    = stra_q;
    strb_d    = strb_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (level_q != '0) begin
          pop = 1'b1;
          if (head_cnt == '0) begin
            done_d = 1'b1;
          end else begin
            opcode_d  = head_op;
            loop_op_d = head_op;
            addra_d   = head_abase;
            addrb_d   = head_bbase;
            stra_d    = head_astr;
            strb_d    = head_bstr;
            cnt_d     = head_cnt;
            idx_d     = '0;
            busy_d    = 1'b1;
            state_d   = S_WAIT_HI;
          end
        end
      end
      S_WAIT_HI: if (flag) state_d = S_WAIT_LO;
      S_WAIT_LO: begin
        if (!flag) begin
          if (more_iter) begin
            opcode_d = loop_op_q;
            addra_d  = addra_q + stra_q;
            addrb_d  = addrb_q + strb_q;
            idx_d    = idx_inc[CNT_BITS-1:0];
`ifdef SEQ_IDLE_SYNC_EN
            state_d  = (idx_q == '0) ? S_SYNC : S_WAIT_HI;
`else
            state_d  = S_WAIT_HI;
`endif
          end else begin
            opcode_d = IDLE_OPCODE;
            state_d  = S_TRAIL_HI;
          end
        end
      end
`ifdef SEQ_IDLE_SYNC_EN
      S_SYNC: if (!idle_flag) state_d = S_WAIT_HI;
`endif
      S_TRAIL_HI: if (flag) state_d = S_TRAIL_LO;
      S_TRAIL_LO: begin
        if (!flag) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      state_q   <= S_IDLE;
      opcode_q  <= IDLE_OPCODE;
      loop_op_q <= IDLE_OPCODE;
      addra_q   <= '0;
      addrb_q   <= '0;
      stra_q    <= '0;
      strb_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      loop_op_q <= loop_op_d;
      addra_q   <= addra_d;
      addrb_q   <= addrb_d;
      stra_q    <= stra_d;
      strb_q    <= strb_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_inst_loop_sequencer.sv
// Scoreboard bench for inst_loop_sequencer: a descriptor-level model queues the expected
// instruction/trailer/done stream, an array model paces flag, and a monitor checks each step.
module tb_inst_loop_sequencer;

  logic        clk;
  logic        reset_n;
  logic        desc_valid;
  logic        desc_ready;
  logic [3:0]  d_op;
  logic [15:0] d_abase, d_astr, d_bbase, d_bstr, d_cnt;
  logic [35:0] instruction;
  logic        flag;
  logic        idle_flag;
  logic        busy;
  logic        done;
  logic [2:0]  fifo_level;

  inst_loop_sequencer dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .desc_valid        (desc_valid),
    .desc_ready        (desc_ready),
    .desc_opcode       (d_op),
    .desc_addra_base   (d_abase),
    .desc_addra_stride (d_astr),
    .desc_addrb_base   (d_bbase),
    .desc_addrb_stride (d_bstr),
    .desc_count        (d_cnt),
    .instruction       (instruction),
    .flag              (flag),
    .idle_flag         (idle_flag),
    .busy              (busy),
    .done              (done),
    .fifo_level        (fifo_level)
  );

  typedef struct {
    bit          is_done;
    logic [35:0] instr;
    int          iter;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_fail   = 0;
  int          last_iter = -1;
  bit          mon_en = 0;
  bit          gen_fixed = 0;
  bit          sync_arm = 0;
  bit          skip_pulse = 0;
  logic        prev_flag;
  logic [35:0] hold_val;
  logic [35:0] exp_idle_instr = '0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Reference: iteration i presents {op, abase + i*astr, bbase + i*bstr} (mod 2^16),
  // then an IDLE trailer with the last addresses, then done; count 0 gives only done.
  task automatic model_enqueue(input logic [3:0] op, input logic [15:0] ab, input logic [15:0] as_,
                               input logic [15:0] bb, input logic [15:0] bs_, input logic [15:0] cnt);
    exp_t e;
    logic [15:0] a, b;
    for (int i = 0; i < int'(cnt); i++) begin
      a = ab + 16'(i) * as_;
      b = bb + 16'(i) * bs_;
      e.is_done = 0;
      e.instr   = {op, a, b};
      e.iter    = i;
      sb_q.push_back(e);
    end
    if (cnt != 0) begin
      a = ab + (cnt - 16'd1) * as_;
      b = bb + (cnt - 16'd1) * bs_;
      e.is_done = 0;
      e.instr   = {4'h0, a, b};
      e.iter    = -1;
      sb_q.push_back(e);
      exp_idle_instr = {4'h0, a, b};
    end
    e.is_done = 1;
    e.instr   = '0;
    e.iter    = -2;
    sb_q.push_back(e);
  endtask

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_desc(input logic [3:0] op, input logic [15:0] ab, input logic [15:0] as_,
                           input logic [15:0] bb, input logic [15:0] bs_, input logic [15:0] cnt);
    int t = 0;
    desc_valid = 1;
    d_op = op; d_abase = ab; d_astr = as_; d_bbase = bb; d_bstr = bs_; d_cnt = cnt;
    while (!desc_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!desc_ready) begin
      fail_now("push_timeout");
      desc_valid = 0;
    end else begin
      model_enqueue(op, ab, as_, bb, bs_, cnt);
      @(negedge clk);
      desc_valid = 0;
      d_op = 4'($urandom); d_abase = 16'($urandom); d_astr = 16'($urandom);
      d_bbase = 16'($urandom); d_bstr = 16'($urandom); d_cnt = 16'($urandom);
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while ((sb_q.size() != 0 || busy || fifo_level != 0) && t < 5000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 5000) begin
      n_fail++;
      $display("FAIL %s: drain timeout, %0d expected items left", name, sb_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  // Array model: steps only while an instruction is outstanding (busy).
  initial begin : array_model
    int hi, lo;
    flag = 0;
    idle_flag = 0;
    forever begin
      @(negedge clk);
      if (reset_n && busy) begin
        hi = gen_fixed ? 3 : int'($urandom_range(1, 4));
        lo = gen_fixed ? 2 : int'($urandom_range(1, 3));
        flag = 1;
        repeat (hi) @(negedge clk);
        flag = 0;
        if (sync_arm && last_iter == 0) begin
          sync_arm = 0;
          @(negedge clk);
          idle_flag = 1;
          @(negedge clk);
`ifdef SEQ_IDLE_SYNC_EN
          skip_pulse = 1;
`endif
          flag = 1;
          repeat (3) @(negedge clk);
          flag = 0;
          repeat (6) @(negedge clk);
          idle_flag = 0;
        end
        repeat (lo - 1) @(negedge clk);
      end
    end
  end

  initial begin : monitor
    prev_flag = 0;
    hold_val  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || !mon_en) begin
        prev_flag = flag;
        hold_val  = instruction;
      end else begin
        if (done) begin
          if (sb_q.size() == 0) fail_now("done_unexpected");
          else begin
            mon_e = sb_q.pop_front();
            chk("done_order", 64'(done), 64'(mon_e.is_done));
            chk("done_busy", 64'(busy), 64'd0);
          end
        end
        if (flag && !prev_flag) begin
          hold_val = instruction;
          if (skip_pulse) skip_pulse = 0;
          else if (sb_q.size() == 0) fail_now("instr_unexpected");
          else begin
            mon_e = sb_q.pop_front();
            chk("instr_kind", 64'(mon_e.is_done), 64'd0);
            chk("instr", 64'(instruction), 64'(mon_e.instr));
            last_iter = mon_e.iter;
          end
        end else if (flag && prev_flag) begin
          chk("instr_stable", 64'(instruction), 64'(hold_val));
        end
        prev_flag = flag;
      end
    end
  end

  initial begin : stim
    int bcount;
    int t;
    reset_n = 0;
    desc_valid = 0;
    d_op = '0; d_abase = '0; d_astr = '0; d_bbase = '0; d_bstr = '0; d_cnt = '0;
    repeat (3) @(negedge clk);
    chk("rst_instr", 64'(instruction), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_level", 64'(fifo_level), 64'd0);
    chk("rst_ready", 64'(desc_ready), 64'd1);
    reset_n = 1;
    mon_en = 1;
    repeat (2) @(negedge clk);
    chk("idle_instr", 64'(instruction), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);

    // 64-iteration loop with a 3-high / 2-low array
    gen_fixed = 1;
    push_desc(4'h1, 16'h0000, 16'h0001, 16'h0000, 16'h0004, 16'd64);
    wait_drain("loop64");
    chk("loop64_trailer", 64'(instruction), 64'({4'h0, 16'd63, 16'd252}));

    // address wrap
    gen_fixed = 0;
    push_desc(4'h2, 16'hFFFE, 16'h0001, 16'h1000, 16'hFFFF, 16'd4);
    wait_drain("wrap");

    // count zero: done only, instruction unchanged, no busy
    push_desc(4'h5, 16'h1234, 16'h0001, 16'h5678, 16'h0001, 16'd0);
    bcount = 0;
    repeat (8) begin
      @(negedge clk);
      if (busy) bcount++;
    end
    chk("cnt0_busy", 64'(bcount), 64'd0);
    chk("cnt0_instr", 64'(instruction), 64'(exp_idle_instr));
    wait_drain("cnt0");

    // FIFO fill while a long loop runs
    push_desc(4'h3, 16'h0010, 16'h0002, 16'h0020, 16'h0003, 16'd8);
    t = 0;
    while ((!busy || fifo_level != 0) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) fail_now("fifo_start_timeout");
    for (int i = 1; i <= 4; i++) begin
      push_desc(4'(i + 6), 16'(i * 16'h0100), 16'h0001, 16'(i * 16'h0200), 16'h0002, 16'(i % 3));
      chk("fifo_level", 64'(fifo_level), 64'(i));
      chk("fifo_ready", 64'(desc_ready), 64'(i < 4));
    end
    push_desc(4'hB, 16'hABCD, 16'h0010, 16'h0F00, 16'h0001, 16'd3);
    wait_drain("fifo");

    // idle_flag sync stall after iteration 0
    gen_fixed = 1;
    last_iter = -1;
    sync_arm = 1;
    push_desc(4'h4, 16'h0100, 16'h0002, 16'h0200, 16'h0003, 16'd4);
    wait_drain("sync");
    chk("sync_exercised", 64'(sync_arm), 64'd0);
    gen_fixed = 0;

    // randomized descriptors
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      push_desc(4'($urandom), 16'($urandom), 16'($urandom_range(0, 3) == 0 ? 0 : $urandom),
                16'($urandom), 16'($urandom), 16'($urandom_range(0, 5)));
    end
    wait_drain("random");

    // asynchronous reset in the middle of a loop with a descriptor queued
    last_iter = -1;
    push_desc(4'h6, 16'h0040, 16'h0001, 16'h0080, 16'h0002, 16'd10);
    push_desc(4'h7, 16'h0001, 16'h0001, 16'h0002, 16'h0001, 16'd3);
    t = 0;
    while (last_iter != 3 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail_now("iter3_timeout");
    chk("pre_reset_level", 64'(fifo_level), 64'd1);
    #2 reset_n = 0;
    #1;
    chk("arst_instr", 64'(instruction), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_level", 64'(fifo_level), 64'd0);
    chk("arst_ready", 64'(desc_ready), 64'd1);
    chk("arst_done", 64'(done), 64'd0);
    mon_en = 0;
    sb_q.delete();
    repeat (3) @(negedge clk);
    reset_n = 1;
    last_iter = -1;
    mon_en = 1;
    repeat (2) @(negedge clk);

    push_desc(4'h9, 16'h0300, 16'h0005, 16'h0400, 16'h0006, 16'd3);
    wait_drain("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
